pipeline_control_unit: RTL and testbench

//  Drives enable/flush of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and PC enable.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/load_use_detect.sv | 22 ++
 rtl/pipeline_control_unit.sv | 137 +++++++++++++
 tb/tb_pipeline_control_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard controller.
//   hazard_state_t : controller state (RUN, DWAIT, SQUASH, HALTED)
//   REG_ZERO       : register index that never carries a dependency
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        SQUASH = 2'd2,
        HALTED = 2'd3
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load sitting in ID/EX whose destination is read
// by the instruction in IF/ID. Writes to register zero never create a hazard.
// Ports:
//   ex_dREN  in  ID/EX holds a load
//   ex_wsel  in  ID/EX destination register
//   id_rs    in  IF/ID source register rs
//   id_rt    in  IF/ID source register rt
//   hazard   out load-use dependency present
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic       ex_dREN,
    input  logic [4:0] ex_wsel,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    assign hazard = ex_dREN && (ex_wsel != REG_ZERO) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline hazard controller: produces enable/flush pairs for the IF/ID,
// ID/EX, EX/MEM and MEM/WB registers plus the PC enable. For each register
// en=1,flush=1 loads a bubble, en=0 holds, and flush is never raised with en=0.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   ihit, dhit                    fetch word valid / data access complete
//   mem_dREN, mem_dWEN            EX/MEM holds a load / store
//   ex_dREN, ex_wsel              ID/EX load and its destination register
//   id_rs, id_rt                  IF/ID source registers
//   mem_br_taken, id_jump         MEM-stage taken branch / ID-stage jump
//   wb_halt                       halt reached MEM/WB
//   pc_en, *_en, *_flush          pipeline register controls
//   halt                          sticky halt
//   stall_cnt                     saturating count of stalled (pc_en=0) cycles
//
// state  | meaning
// RUN    | normal flow, hazards resolved by priority each cycle
// DWAIT  | data memory access outstanding, pipeline frozen above MEM/WB
// SQUASH | redirect taken while a fetch was in flight; drop the returning word
// HALTED | halt retired; everything frozen until reset
module pipeline_control_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             mem_br_taken,
    input  logic             id_jump,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    hazard_state_t state;
    hazard_state_t next_state;
    logic          load_use;
    logic          mem_stall;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    load_use_detect u_load_use (
        .ex_dREN (ex_dREN),
        .ex_wsel (ex_wsel),
        .id_rs   (id_rs),
        .id_rt   (id_rt),
        .hazard  (load_use)
    );

    // Once in DWAIT the access is still outstanding even if the mem-op
    // strobes are momentarily deasserted, so only dhit releases it.
    assign mem_stall = ((mem_dREN || mem_dWEN) || (state == DWAIT)) && !dhit;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        next_state  = (state == SQUASH) ? SQUASH : RUN;

        if ((state == HALTED) || wb_halt) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            next_state = HALTED;
        end else if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            next_state  = DWAIT;
        end else if (mem_br_taken) begin
            // Wins over load-use: the dependent instruction is on the wrong path.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            next_state  = ((state == SQUASH) || !ihit) ? SQUASH : RUN;
        end else if (state == SQUASH) begin
            // PC already points at the target; the word arriving now is stale.
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            next_state = ihit ? RUN : SQUASH;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            pc_en      = ihit;
            ifid_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            halt  <= (next_state == HALTED);
            if (!pc_en && (state != HALTED) && (next_state != HALTED) &&
                (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: each stimulus cycle pushes the
// hand-computed expected controls; a negedge monitor pops and compares.
module tb_pipeline_control_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
    logic [4:0]  ex_wsel, id_rs, id_rt;
    logic        mem_br_taken, id_jump, wb_halt;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
    logic [31:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    // ctrl bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    //                 exmem_en, exmem_flush, memwb_en, memwb_flush
    localparam logic [8:0] V_RUN    = 9'b1_10_10_10_10;
    localparam logic [8:0] V_LDUSE  = 9'b0_00_11_10_10;
    localparam logic [8:0] V_DWAIT  = 9'b0_00_00_00_11;
    localparam logic [8:0] V_BRANCH = 9'b1_11_11_11_10;
    localparam logic [8:0] V_NOFET  = 9'b0_11_10_10_10;
    localparam logic [8:0] V_JUMP   = 9'b1_11_10_10_10;
    localparam logic [8:0] V_HALT   = 9'b0_00_00_00_00;

    typedef struct {
        string       name;
        logic [8:0]  ctrl;
        logic        halt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    pipeline_control_unit #(.CNT_W(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ihit         (ihit),
        .dhit         (dhit),
        .mem_dREN     (mem_dREN),
        .mem_dWEN     (mem_dWEN),
        .ex_dREN      (ex_dREN),
        .ex_wsel      (ex_wsel),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .mem_br_taken (mem_br_taken),
        .id_jump      (id_jump),
        .wb_halt      (wb_halt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .exmem_flush  (exmem_flush),
        .memwb_en     (memwb_en),
        .memwb_flush  (memwb_flush),
        .halt         (halt),
        .stall_cnt    (stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Monitor: one output per cycle, compared at the falling edge.
    initial begin
        exp_t       e;
        logic [8:0] act;
        logic [3:0] fl, en;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                       exmem_en, exmem_flush, memwb_en, memwb_flush};
                checks++;
                if (act !== e.ctrl || halt !== e.halt || stall_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: ctrl=%b halt=%b cnt=%0d, expected ctrl=%b halt=%b cnt=%0d",
                             e.name, act, halt, stall_cnt, e.ctrl, e.halt, e.cnt);
                end
                en = {ifid_en, idex_en, exmem_en, memwb_en};
                fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
                checks++;
                if ((fl & ~en) !== 4'b0000) begin
                    failures++;
                    $display("FAIL %s flush_without_en: flush=%b en=%b, expected no flush with en=0",
                             e.name, fl, en);
                end
            end
        end
    end

    task automatic step(input string name, input logic [8:0] ctrl,
                        input logic h, input logic [31:0] cnt);
        exp_t e;
        e.name = name;
        e.ctrl = ctrl;
        e.halt = h;
        e.cnt  = cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_dREN = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        mem_br_taken = 1'b0; id_jump = 1'b0; wb_halt = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        @(posedge CLK); #1;
        step("reset", V_RUN, 1'b0, 32'd0);
        RST = 1'b0;
        step("run", V_RUN, 1'b0, 32'd0);

        ex_dREN = 1'b1; ex_wsel = 5'd8; id_rt = 5'd8;
        step("ld_use_rt", V_LDUSE, 1'b0, 32'd0);
        idle();
        step("after_ld_use", V_RUN, 1'b0, 32'd1);
        ex_dREN = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0;
        step("ld_r0_nostall", V_RUN, 1'b0, 32'd1);
        ex_wsel = 5'd5; id_rs = 5'd6; id_rt = 5'd7;
        step("ld_nomatch", V_RUN, 1'b0, 32'd1);
        ex_wsel = 5'd9; id_rs = 5'd9;
        step("ld_use_rs", V_LDUSE, 1'b0, 32'd1);
        idle();

        mem_dREN = 1'b1;
        step("dwait1", V_DWAIT, 1'b0, 32'd2);
        step("dwait2", V_DWAIT, 1'b0, 32'd3);
        step("dwait3", V_DWAIT, 1'b0, 32'd4);
        dhit = 1'b1;
        step("dhit", V_RUN, 1'b0, 32'd5);
        idle();
        mem_dWEN = 1'b1;
        step("store_wait", V_DWAIT, 1'b0, 32'd5);
        dhit = 1'b1;
        step("store_hit", V_RUN, 1'b0, 32'd6);
        idle();

        mem_br_taken = 1'b1; ihit = 1'b0;
        step("br_noihit", V_BRANCH, 1'b0, 32'd6);
        mem_br_taken = 1'b0;
        step("squash_wait", V_NOFET, 1'b0, 32'd6);
        ihit = 1'b1;
        step("squash_word", V_NOFET, 1'b0, 32'd7);
        step("post_squash", V_RUN, 1'b0, 32'd8);

        mem_br_taken = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd8; id_rt = 5'd8;
        step("br_over_lduse", V_BRANCH, 1'b0, 32'd8);
        idle();
        step("br_ihit_run", V_RUN, 1'b0, 32'd8);

        id_jump = 1'b1;
        step("jump_ihit", V_JUMP, 1'b0, 32'd8);
        ihit = 1'b0;
        step("jump_noihit", V_NOFET, 1'b0, 32'd8);
        idle();
        ihit = 1'b0;
        step("no_ihit", V_NOFET, 1'b0, 32'd9);
        ihit = 1'b1;
        step("ihit_back", V_RUN, 1'b0, 32'd10);

        wb_halt = 1'b1;
        step("wb_halt", V_HALT, 1'b0, 32'd10);
        idle();
        step("halted1", V_HALT, 1'b1, 32'd10);
        ihit = 1'b0;
        step("halted_noihit", V_HALT, 1'b1, 32'd10);
        mem_br_taken = 1'b1; mem_dREN = 1'b1;
        step("halted_br", V_HALT, 1'b1, 32'd10);
        idle();
        RST = 1'b1;
        step("rst_in_halt", V_HALT, 1'b1, 32'd10);
        RST = 1'b0;
        step("after_rst", V_RUN, 1'b0, 32'd0);

        @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
